// File: rtl/sysid_pkg.sv
// Shared types and constants for the system-ID boot checker.
package sysid_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_ID,
        WT_ID,
        RD_TS,
        WT_TS,
        CHECK,
        DONE
    } state_t;

    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

    localparam logic [31:0] SYSID_DEFAULT_ID        = 32'd0;
    localparam logic [31:0] SYSID_DEFAULT_TIMESTAMP = 32'd1489951972;

endpackage

// File: rtl/sysid_timeout_counter.sv
// Per-state cycle counter; expire fires on the LIMIT-th enabled cycle since the last load.
module sysid_timeout_counter #(
    parameter logic [7:0] LIMIT = 8'd255
) (
    input  logic clock,
    input  logic reset_n,
    input  logic load,
    input  logic enable,
    output logic expire
);

    logic [7:0] count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= 8'd0;
        end else if (load) begin
            count <= 8'd0;
        end else if (enable) begin
            count <= count + 8'd1;
        end
    end

    assign expire = enable && (count == LIMIT - 8'd1);

endmodule

// File: rtl/sysid_boot_checker.sv
// Avalon-MM read master that fetches the system ID and build timestamp and
// compares them against build-time expected values, retrying on bus timeout.
module sysid_boot_checker
    import sysid_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID        = SYSID_DEFAULT_ID,
    parameter logic [31:0] EXPECTED_TIMESTAMP = SYSID_DEFAULT_TIMESTAMP,
    parameter int          USE_READDATAVALID  = 0,
    parameter int          TIMEOUT_CYCLES     = 255,
    parameter int          MAX_RETRIES        = 3,
    parameter int          AUTO_START         = 1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        fail,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value,
    output logic [1:0]  retry_count
);

    localparam logic [1:0] RETRY_LIMIT = 2'(MAX_RETRIES);
    localparam bit         RDV_MODE    = (USE_READDATAVALID != 0);

    state_t state, state_next;
    logic   auto_pend;
    logic   accept, expire, timer_load, timer_en;
    logic   clear, cap_id, cap_ts, retry, give_up, check;

    assign avm_read    = (state == RD_ID) || (state == RD_TS);
    assign avm_address = (state == RD_TS) ? SYSID_ADDR_TS : SYSID_ADDR_ID;
    assign accept      = avm_read && !avm_waitrequest;
    assign busy        = (state != IDLE) && (state != DONE);
    assign timer_en    = (state == RD_ID) || (state == WT_ID) ||
                         (state == RD_TS) || (state == WT_TS);
    // Retry re-enters RD_ID from RD_ID, so a self-transition must also reload.
    assign timer_load  = (state_next != state) || retry;

    sysid_timeout_counter #(
        .LIMIT (8'(TIMEOUT_CYCLES))
    ) u_timer (
        .clock   (clock),
        .reset_n (reset_n),
        .load    (timer_load),
        .enable  (timer_en),
        .expire  (expire)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            auto_pend <= (AUTO_START != 0);
        end else begin
            state     <= state_next;
            auto_pend <= 1'b0;
        end
    end

    always_comb begin
        state_next = state;
        clear      = 1'b0;
        cap_id     = 1'b0;
        cap_ts     = 1'b0;
        retry      = 1'b0;
        give_up    = 1'b0;
        check      = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start || auto_pend) begin
                    clear      = 1'b1;
                    state_next = RD_ID;
                end
            end
            RD_ID: begin
                if (accept) begin
                    if (RDV_MODE) begin
                        state_next = WT_ID;
                    end else begin
                        cap_id     = 1'b1;
                        state_next = RD_TS;
                    end
                end
            end
            WT_ID: begin
                if (avm_readdatavalid) begin
                    cap_id     = 1'b1;
                    state_next = RD_TS;
                end
            end
            RD_TS: begin
                if (accept) begin
                    if (RDV_MODE) begin
                        state_next = WT_TS;
                    end else begin
                        cap_ts     = 1'b1;
                        state_next = CHECK;
                    end
                end
            end
            WT_TS: begin
                if (avm_readdatavalid) begin
                    cap_ts     = 1'b1;
                    state_next = CHECK;
                end
            end
            CHECK: begin
                check      = 1'b1;
                state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
        // A completing read or data beat on the expiry cycle takes priority.
        if (expire && (state_next == state)) begin
            if (retry_count < RETRY_LIMIT) begin
                retry      = 1'b1;
                state_next = RD_ID;
            end else begin
                give_up    = 1'b1;
                state_next = DONE;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            done        <= 1'b0;
            pass        <= 1'b0;
            fail        <= 1'b0;
            id_ok       <= 1'b0;
            ts_ok       <= 1'b0;
            timeout     <= 1'b0;
            id_value    <= 32'd0;
            ts_value    <= 32'd0;
            retry_count <= 2'd0;
        end else begin
            if (clear) begin
                done        <= 1'b0;
                pass        <= 1'b0;
                fail        <= 1'b0;
                id_ok       <= 1'b0;
                ts_ok       <= 1'b0;
                timeout     <= 1'b0;
                retry_count <= 2'd0;
            end
            if (retry)  retry_count <= retry_count + 2'd1;
            if (cap_id) id_value    <= avm_readdata;
            if (cap_ts) ts_value    <= avm_readdata;
            if (check) begin
                id_ok <= (id_value == EXPECTED_ID);
                ts_ok <= (ts_value == EXPECTED_TIMESTAMP);
                pass  <= (id_value == EXPECTED_ID) && (ts_value == EXPECTED_TIMESTAMP);
                fail  <= !((id_value == EXPECTED_ID) && (ts_value == EXPECTED_TIMESTAMP));
                done  <= 1'b1;
            end
            if (give_up) begin
                timeout <= 1'b1;
                fail    <= 1'b1;
                pass    <= 1'b0;
                done    <= 1'b1;
                id_ok   <= 1'b0;
                ts_ok   <= 1'b0;
            end
        end
    end

endmodule
